// File: rtl/cpu_datapath_pkg.sv
// ============================================================================
// Module      : cpu_datapath_pkg
// Description : Shared definitions for the CPU datapath and its ALU.
//               - Control-word bit indices (bit n of the CU control word = Cn)
//               - Flag bit positions inside the {ZF,CF,OF,SF} register
//               - ALU one-hot operation encoding and request gathering
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_datapath_pkg;

    // ------------------------------------------------------------------
    // Control-word bit indices. The control unit uses the same table.
    // ------------------------------------------------------------------
    localparam int unsigned C_MBR_LD_MEM = 3;   // MBR <- mem_rdata
    localparam int unsigned C_IR_LD_MBR  = 4;   // IR  <- MBR
    localparam int unsigned C_MAR_LD_MBR = 5;   // MAR <- MBR[addr]
    localparam int unsigned C_PC_INC     = 6;   // PC  <- PC + 1
    localparam int unsigned C_BR_LD_MBR  = 7;   // BR  <- MBR
    localparam int unsigned C_ACC_CLR    = 8;   // ACC <- 0
    localparam int unsigned C_ACC_ADD    = 9;   // ACC <- ACC + BR
    localparam int unsigned C_MAR_LD_PC  = 10;  // MAR <- PC
    localparam int unsigned C_MEM_WR     = 11;  // Mem[MAR] <- MBR
    localparam int unsigned C_MBR_LD_ACC = 12;  // MBR <- ACC
    localparam int unsigned C_ACC_SUB    = 13;  // ACC <- ACC - BR
    localparam int unsigned C_PC_LD_MBR  = 14;  // PC  <- MBR[addr]
    localparam int unsigned C_ACC_MUL    = 15;  // ACC <- low half of ACC * BR
    localparam int unsigned C_ACC_DIV    = 16;  // ACC <- ACC / BR
    localparam int unsigned C_ACC_SHL    = 17;  // ACC <- ACC << BR
    localparam int unsigned C_ACC_SHR    = 18;  // ACC <- ACC >> BR
    localparam int unsigned C_ACC_AND    = 19;  // ACC <- ACC & BR
    localparam int unsigned C_ACC_OR     = 20;  // ACC <- ACC | BR
    localparam int unsigned C_ACC_NOT    = 21;  // ACC <- ~BR

    // Flag register bit positions
    localparam int unsigned FLAG_ZF = 3;
    localparam int unsigned FLAG_CF = 2;
    localparam int unsigned FLAG_OF = 1;
    localparam int unsigned FLAG_SF = 0;

    typedef struct packed {
        logic zf;
        logic cf;
        logic of;
        logic sf;
    } flags_t;

    // Bit positions of the ALU one-hot op vector. Ordering follows the
    // control-word index so that the lowest vector bit is the winning op.
    typedef enum int unsigned {
        OP_CLR = 0,
        OP_ADD = 1,
        OP_SUB = 2,
        OP_MUL = 3,
        OP_DIV = 4,
        OP_SHL = 5,
        OP_SHR = 6,
        OP_AND = 7,
        OP_OR  = 8,
        OP_NOT = 9
    } alu_op_e;

    localparam int unsigned NUM_ALU_OPS = 10;

    typedef logic [NUM_ALU_OPS-1:0] alu_onehot_t;

    // Collects every ACC-op request bit of the control word into a vector
    // ordered by ascending control index.
    function automatic alu_onehot_t acc_op_requests(input logic [31:0] ctrl);
        alu_onehot_t req;
        req[OP_CLR] = ctrl[C_ACC_CLR];
        req[OP_ADD] = ctrl[C_ACC_ADD];
        req[OP_SUB] = ctrl[C_ACC_SUB];
        req[OP_MUL] = ctrl[C_ACC_MUL];
        req[OP_DIV] = ctrl[C_ACC_DIV];
        req[OP_SHL] = ctrl[C_ACC_SHL];
        req[OP_SHR] = ctrl[C_ACC_SHR];
        req[OP_AND] = ctrl[C_ACC_AND];
        req[OP_OR]  = ctrl[C_ACC_OR];
        req[OP_NOT] = ctrl[C_ACC_NOT];
        return req;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_datapath_alu.sv
// ============================================================================
// Module      : cpu_alu
// Description : Combinational ALU for the CPU datapath.
//               Ports:
//                 acc    in  DATA_W  accumulator operand
//                 br     in  DATA_W  buffer-register operand
//                 op     in  10      one-hot operation select
//                 result out DATA_W  new accumulator value
//                 flags  out 4       {ZF,CF,OF,SF} for the new value
//               With no op bit set the outputs are don't-care; the datapath
//               only samples them on ACC-op cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] br,
    input  alu_onehot_t       op,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned MSB  = DATA_W - 1;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_divisor;
    logic [DATA_W-1:0]   w_quot;
    logic [SH_W-1:0]     w_shamt;
    logic                w_sh_big;
    logic [DATA_W:0]     w_shl;
    logic [DATA_W:0]     w_shr;
    logic                w_add_of;
    logic                w_sub_of;
    logic                w_cf;
    logic                w_of;
    flags_t              w_flags;

    assign w_sum  = {1'b0, acc} + {1'b0, br};
    // Top bit of the widened difference is the borrow (acc < br).
    assign w_diff = {1'b0, acc} - {1'b0, br};
    assign w_prod = acc * br;

    // Divide-by-zero is handled explicitly below; the substitute divisor
    // only keeps the divider from producing X.
    assign w_divisor = (br == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : br;
    assign w_quot    = acc / w_divisor;

    // Shifting through one extra bit leaves the last bit shifted out in
    // the extra position; a zero shift leaves that bit 0.
    assign w_shamt  = br[SH_W-1:0];
    assign w_sh_big = |br[DATA_W-1:SH_W];
    assign w_shl    = {1'b0, acc} << w_shamt;
    assign w_shr    = {acc, 1'b0} >> w_shamt;

    assign w_add_of = (acc[MSB] == br[MSB]) && (w_sum[MSB]  != acc[MSB]);
    assign w_sub_of = (acc[MSB] != br[MSB]) && (w_diff[MSB] != acc[MSB]);

    always_comb begin
        result = '0;
        w_cf   = 1'b0;
        w_of   = 1'b0;
        case (1'b1)
            op[OP_CLR]: result = '0;
            op[OP_ADD]: begin
                result = w_sum[DATA_W-1:0];
                w_cf   = w_sum[DATA_W];
                w_of   = w_add_of;
            end
            op[OP_SUB]: begin
                result = w_diff[DATA_W-1:0];
                w_cf   = w_diff[DATA_W];
                w_of   = w_sub_of;
            end
            op[OP_MUL]: begin
                result = w_prod[DATA_W-1:0];
                w_cf   = |w_prod[2*DATA_W-1:DATA_W];
                w_of   = |w_prod[2*DATA_W-1:DATA_W];
            end
            op[OP_DIV]: begin
                if (br == '0) begin
                    result = '1;
                    w_of   = 1'b1;
                end else begin
                    result = w_quot;
                end
            end
            op[OP_SHL]: begin
                if (!w_sh_big) begin
                    result = w_shl[DATA_W-1:0];
                    w_cf   = w_shl[DATA_W];
                end
            end
            op[OP_SHR]: begin
                if (!w_sh_big) begin
                    result = w_shr[DATA_W:1];
                    w_cf   = w_shr[0];
                end
            end
            op[OP_AND]: result = acc & br;
            op[OP_OR]:  result = acc | br;
            op[OP_NOT]: result = ~br;
            default:    result = '0;
        endcase
    end

    assign w_flags.zf = (result == '0);
    assign w_flags.cf = w_cf;
    assign w_flags.of = w_of;
    assign w_flags.sf = result[MSB];
    assign flags      = w_flags;

endmodule

`default_nettype wire

// File: rtl/cpu_datapath.sv
// ============================================================================
// Module      : cpu_datapath
// Description : Register-transfer datapath driven by the microprogrammed
//               control unit's 32-bit control word (bit n = Cn).
//               Ports:
//                 clk           in  1       rising-edge clock
//                 rst_n         in  1       asynchronous active-low reset
//                 ctrl          in  32      control word; bits 0..2, 22..31 unused
//                 mem_rdata     in  DATA_W  combinational read of Mem[mem_addr]
//                 mem_addr      out ADDR_W  MAR
//                 mem_wdata     out DATA_W  MBR
//                 mem_we        out 1       write strobe (C11)
//                 ir_out        out DATA_W  IR; [15:8] is the opcode
//                 alu_flags     out 4       {ZF,CF,OF,SF}
//                 acc_out       out DATA_W  ACC
//                 pc_out        out ADDR_W  PC
//                 ctrl_conflict out 1       one cycle after >1 ACC-op bit was set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] ir_out,
    output logic [3:0]        alu_flags,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ctrl_conflict
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mbr;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_br;
    logic [DATA_W-1:0] r_acc;
    logic [3:0]        r_flags;
    logic              r_conflict;

    alu_onehot_t       w_acc_req;
    alu_onehot_t       w_alu_op;
    logic              w_acc_we;
    logic              w_multi_req;
    logic [DATA_W-1:0] w_alu_result;
    logic [3:0]        w_alu_flags;
    logic              w_unused_ctrl;

    assign w_unused_ctrl = ^{ctrl[31:22], ctrl[2:0]};

    // Lowest set request bit wins: x & -x isolates it. More than one
    // request leaves bits behind after clearing the lowest (x & (x-1)).
    assign w_acc_req   = acc_op_requests(ctrl);
    assign w_alu_op    = w_acc_req & (~w_acc_req + 1'b1);
    assign w_acc_we    = |w_acc_req;
    assign w_multi_req = |(w_acc_req & (w_acc_req - 1'b1));

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc    (r_acc),
        .br     (r_br),
        .op     (w_alu_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_mar      <= '0;
            r_mbr      <= '0;
            r_ir       <= '0;
            r_br       <= '0;
            r_acc      <= '0;
            r_flags    <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (ctrl[C_MBR_LD_MEM]) begin
                r_mbr <= mem_rdata;
            end else if (ctrl[C_MBR_LD_ACC]) begin
                r_mbr <= r_acc;
            end

            if (ctrl[C_IR_LD_MBR]) begin
                r_ir <= r_mbr;
            end

            if (ctrl[C_BR_LD_MBR]) begin
                r_br <= r_mbr;
            end

            if (ctrl[C_MAR_LD_MBR]) begin
                r_mar <= r_mbr[ADDR_W-1:0];
            end else if (ctrl[C_MAR_LD_PC]) begin
                r_mar <= r_pc;
            end

            if (ctrl[C_PC_LD_MBR]) begin
                r_pc <= r_mbr[ADDR_W-1:0];
            end else if (ctrl[C_PC_INC]) begin
                r_pc <= r_pc + 1'b1;
            end

            if (w_acc_we) begin
                r_acc   <= w_alu_result;
                r_flags <= w_alu_flags;
            end

            r_conflict <= w_multi_req;
        end
    end

    // Gated by rst_n so a write in flight is dropped the moment reset hits.
    assign mem_we        = ctrl[C_MEM_WR] & rst_n;
    assign mem_addr      = r_mar;
    assign mem_wdata     = r_mbr;
    assign ir_out        = r_ir;
    assign alu_flags     = r_flags;
    assign acc_out       = r_acc;
    assign pc_out        = r_pc;
    assign ctrl_conflict = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Self-checking bench for cpu_datapath. Owns the memory,
//               drives control words and compares against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] ir_out;
    logic [3:0]  alu_flags;
    logic [15:0] acc_out;
    logic [7:0]  pc_out;
    logic        ctrl_conflict;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_datapath #(
        .DATA_W (16),
        .ADDR_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl          (ctrl),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .ir_out        (ir_out),
        .alu_flags     (alu_flags),
        .acc_out       (acc_out),
        .pc_out        (pc_out),
        .ctrl_conflict (ctrl_conflict)
    );

    // Memory environment; ov_en lets a step present an arbitrary read word.
    logic [15:0] mem      [256];
    logic [15:0] init_mem [256];
    logic        load_mem;
    logic        ov_en;
    logic [15:0] ov_data;

    assign mem_rdata = ov_en ? ov_data : mem[mem_addr];

    always @(posedge clk) begin
        if (load_mem)    mem <= init_mem;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Reference model state
    logic [7:0]  m_pc, m_mar;
    logic [15:0] m_mbr, m_ir, m_br, m_acc;
    logic [3:0]  m_flags;
    logic        m_conf;
    logic [15:0] m_mem [256];

    localparam logic [31:0] B3  = 32'd1 << 3,  B4  = 32'd1 << 4,  B5  = 32'd1 << 5;
    localparam logic [31:0] B6  = 32'd1 << 6,  B7  = 32'd1 << 7,  B8  = 32'd1 << 8;
    localparam logic [31:0] B9  = 32'd1 << 9,  B11 = 32'd1 << 11, B12 = 32'd1 << 12;
    localparam logic [31:0] B13 = 32'd1 << 13, B14 = 32'd1 << 14, B15 = 32'd1 << 15;
    localparam logic [31:0] B16 = 32'd1 << 16, B17 = 32'd1 << 17, B18 = 32'd1 << 18;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ALU rules expressed with integer arithmetic.
    task automatic alu_ref(input int op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic [3:0] f);
        int     ua, ub, sa, sb, s;
        longint p;
        logic   cf, of;
        ua = int'(a); ub = int'(b);
        sa = $signed(a); sb = $signed(b);
        cf = 1'b0; of = 1'b0; r = 16'h0000;
        case (op)
            8:  r = 16'h0000;
            9:  begin
                    s = ua + ub; r = s[15:0]; cf = (s > 65535);
                    s = sa + sb; of = (s > 32767) || (s < -32768);
                end
            13: begin
                    s = ua - ub; r = s[15:0]; cf = (ua < ub);
                    s = sa - sb; of = (s > 32767) || (s < -32768);
                end
            15: begin
                    p = longint'(ua) * longint'(ub); r = p[15:0];
                    cf = (p > 65535); of = cf;
                end
            16: begin
                    if (ub == 0) begin r = 16'hFFFF; of = 1'b1; end
                    else r = 16'(ua / ub);
                end
            17: begin
                    if (ub <= 15) begin
                        p = longint'(ua) * longint'(2 ** ub);
                        r = p[15:0]; cf = (ub > 0) && p[16];
                    end
                end
            18: begin
                    if (ub <= 15) begin
                        r = 16'(ua / (2 ** ub));
                        cf = (ub > 0) && (((ua / (2 ** (ub - 1))) % 2) == 1);
                    end
                end
            19: r = a & b;
            20: r = a | b;
            default: r = ~b;
        endcase
        f = {(r == 16'h0000), cf, of, r[15]};
    endtask

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0; m_br = 0; m_acc = 0;
        m_flags = 0; m_conf = 0;
    endtask

    task automatic model_step(input logic [31:0] c);
        logic [15:0] rd, n_mbr, n_ir, n_br, n_acc, r;
        logic [7:0]  n_mar, n_pc;
        logic [3:0]  n_fl, f;
        int          ops[10];
        int          nset, first;
        ops   = '{8, 9, 13, 15, 16, 17, 18, 19, 20, 21};
        rd    = ov_en ? ov_data : m_mem[m_mar];
        n_mbr = c[3] ? rd : (c[12] ? m_acc : m_mbr);
        n_ir  = c[4] ? m_mbr : m_ir;
        n_br  = c[7] ? m_mbr : m_br;
        n_mar = c[5] ? m_mbr[7:0] : (c[10] ? m_pc : m_mar);
        n_pc  = c[14] ? m_mbr[7:0] : (c[6] ? m_pc + 8'd1 : m_pc);
        nset = 0; first = -1;
        foreach (ops[i]) begin
            if (c[ops[i]]) begin
                nset++;
                if (first < 0) first = ops[i];
            end
        end
        n_acc = m_acc; n_fl = m_flags;
        if (first >= 0) begin
            alu_ref(first, m_acc, m_br, r, f);
            n_acc = r; n_fl = f;
        end
        if (c[11]) m_mem[m_mar] = m_mbr;
        m_mbr = n_mbr; m_ir = n_ir; m_br = n_br; m_mar = n_mar; m_pc = n_pc;
        m_acc = n_acc; m_flags = n_fl; m_conf = (nset > 1);
    endtask

    task automatic check_state(input string ph);
        check({ph, ".acc"},  acc_out,       m_acc);
        check({ph, ".pc"},   pc_out,        m_pc);
        check({ph, ".ir"},   ir_out,        m_ir);
        check({ph, ".mar"},  mem_addr,      m_mar);
        check({ph, ".mbr"},  mem_wdata,     m_mbr);
        check({ph, ".flg"},  alu_flags,     m_flags);
        check({ph, ".conf"}, ctrl_conflict, m_conf);
    endtask

    // One control word for one clock: applied at the falling edge,
    // results sampled 1 ns after the following rising edge.
    task automatic step(input logic [31:0] c, input string ph);
        @(negedge clk);
        ctrl = c;
        #1;
        check({ph, ".we"}, mem_we, c[11]);
        model_step(c);
        @(posedge clk);
        #1;
        check_state(ph);
    endtask

    task automatic load_mbr(input logic [15:0] v);
        ov_en = 1'b1; ov_data = v;
        step(B3, "ldmbr");
        ov_en = 1'b0;
    endtask

    task automatic load_br(input logic [15:0] v);
        load_mbr(v);
        step(B7, "ldbr");
    endtask

    task automatic load_acc(input logic [15:0] v);
        load_br(v);
        step(B8, "ldacc_clr");
        step(B9, "ldacc_add");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c;
        logic [7:0]  saved_addr;
        logic [15:0] saved_word;

        rst_n = 1'b0; ctrl = 32'h0; ov_en = 1'b0; ov_data = 16'h0; load_mem = 1'b1;
        foreach (init_mem[i]) init_mem[i] = 16'($urandom);
        init_mem[0] = 16'h0210;
        foreach (m_mem[i]) m_mem[i] = init_mem[i];
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check("reset.we", mem_we, 1'b0);
        @(negedge clk);
        load_mem = 1'b0;
        rst_n    = 1'b1;

        // Instruction fetch
        step(B3, "fetch1");
        check("fetch.mbr", mem_wdata, 16'h0210);
        step(B4, "fetch2");
        check("fetch.op", ir_out[15:8], 8'h02);
        step(B5 | B6, "fetch3");
        check("fetch.mar", mem_addr, 8'h10);
        check("fetch.pc",  pc_out,   8'h01);

        // Add overflow, then subtract to zero
        load_acc(16'h7FFF); load_br(16'h0001);
        step(B9, "add");
        check("add.acc", acc_out, 16'h8000);
        check("add.flg", alu_flags, 4'b0011);
        load_br(16'h8000);
        step(B13, "sub");
        check("sub.acc", acc_out, 16'h0000);
        check("sub.flg", alu_flags, 4'b1000);

        // Multiply overflow, divide by zero
        load_acc(16'h0100); load_br(16'h0100);
        step(B15, "mul");
        check("mul.acc", acc_out, 16'h0000);
        check("mul.flg", alu_flags, 4'b1110);
        load_acc(16'h0005); load_br(16'h0000);
        step(B16, "div0");
        check("div0.acc", acc_out, 16'hFFFF);
        check("div0.flg", alu_flags, 4'b0011);

        // Shifts
        load_acc(16'h8001); load_br(16'h0001);
        step(B17, "shl");
        check("shl.acc", acc_out, 16'h0002);
        check("shl.cf",  alu_flags[2], 1'b1);
        load_br(16'd20);
        step(B18, "shr_big");
        check("shr_big.acc", acc_out, 16'h0000);
        check("shr_big.flg", alu_flags, 4'b1000);

        // Priority and wrap
        load_mbr(16'h00FF);
        step(B14, "pcld");
        step(B6, "pcwrap");
        check("pcwrap.pc", pc_out, 8'h00);
        load_mbr(16'h0033);
        step(B6 | B14, "pcprio");
        check("pcprio.pc", pc_out, 8'h33);
        load_acc(16'h4321);
        ov_en = 1'b1; ov_data = 16'h1234;
        step(B3 | B12, "mbrprio");
        ov_en = 1'b0;
        check("mbrprio.mbr", mem_wdata, 16'h1234);
        load_br(16'h0011);
        step(B9 | B13, "conflict");
        check("conflict.acc",  acc_out, 16'h4332);
        check("conflict.flag", ctrl_conflict, 1'b1);
        step(32'h0, "nop");
        check("nop.conf", ctrl_conflict, 1'b0);
        step(B12, "store1");
        step(B11, "store2");
        check("store.mem", mem[mem_addr], 16'h4332);

        // Randomized control words
        for (int n = 0; n < 400; n++) begin
            c = $urandom & 32'hFFC0_0007;
            for (int b = 3; b <= 21; b++) begin
                if ($urandom_range(0, 7) == 0) c[b] = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) c = 32'h0;
            step(c, "rand");
        end

        // Asynchronous reset in the middle of a write
        load_acc(16'hBEEF);
        step(B12, "prerst");
        @(negedge clk);
        ctrl       = B11 | B9;
        saved_addr = m_mar;
        saved_word = m_mem[m_mar];
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        check("async_rst.we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        check("async_rst.nowrite", mem[saved_addr], saved_word);
        @(negedge clk);
        ctrl  = 32'h0;
        rst_n = 1'b1;

        for (int n = 0; n < 100; n++) begin
            c = 32'h0;
            for (int b = 3; b <= 21; b++) begin
                if ($urandom_range(0, 5) == 0) c[b] = 1'b1;
            end
            step(c, "rand2");
        end

        foreach (m_mem[i]) check("mem_final", mem[i], m_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
